// File: rtl/axi_llc_data_way.sv
// rtl/axi_llc_data_way.sv - one LLC data way: zero-init, strobe-merged writes, 1-cycle reads
package axi_llc_data_way_pkg;
    typedef struct packed {
        logic [1:0]  cache_unit;
        logic [7:0]  way_ind;
        logic [7:0]  line_addr;
        logic [2:0]  blk_offset;
        logic        we;
        logic [63:0] data;
        logic [7:0]  strb;
    } way_inp_t;

    typedef struct packed {
        logic [1:0]  cache_unit;
        logic [63:0] read_data;
    } way_oup_t;
endpackage

module axi_llc_data_way #(
    parameter int unsigned WayIndex  = 0,
    parameter int unsigned NumLines  = 256,
    parameter int unsigned NumBlocks = 8,
    parameter int unsigned DataWidth = 64,
    parameter type way_inp_t = axi_llc_data_way_pkg::way_inp_t,
    parameter type way_oup_t = axi_llc_data_way_pkg::way_oup_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     test_i,
    input  way_inp_t inp_i,
    input  logic     inp_valid_i,
    output logic     inp_ready_o,
    output way_oup_t oup_o,
    output logic     oup_valid_o,
    input  logic     oup_ready_i,
    output logic     init_done_o
);
    localparam int unsigned NumWords  = NumLines * NumBlocks;
    localparam int unsigned AddrWidth = $clog2(NumWords);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

    state_t                 state_q;
    logic [AddrWidth-1:0]   cnt_q;
    way_oup_t               oup_q;
    logic [DataWidth-1:0]   mem [NumWords];
    logic [AddrWidth-1:0]   addr;
    logic                   accept;
    logic                   mem_we;
    logic                   unused_test;

    assign unused_test = test_i;
    assign addr        = {inp_i.line_addr, inp_i.blk_offset};
    assign accept      = inp_valid_i && inp_ready_o;
    assign mem_we      = accept && inp_i.we;

    // Responding blocks new requests unless the pending response leaves this cycle.
    always_comb begin
        inp_ready_o = 1'b0;
        case (state_q)
            IDLE:    inp_ready_o = 1'b1;
            RESP:    inp_ready_o = oup_ready_i;
            default: inp_ready_o = 1'b0;
        endcase
    end

    assign oup_valid_o = (state_q == RESP);
    assign init_done_o = (state_q != INIT);
    assign oup_o       = oup_q;

    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (mem_we) begin
            for (int i = 0; i < StrbWidth; i++) begin
                if (inp_i.strb[i]) begin
                    mem[addr][i*8 +: 8] <= inp_i.data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
            oup_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastAddr) begin
                        state_q <= IDLE;
                    end
                end
                IDLE, RESP: begin
                    if (accept && !inp_i.we) begin
                        state_q          <= RESP;
                        oup_q.cache_unit <= inp_i.cache_unit;
                        oup_q.read_data  <= mem[addr];
                    end else if (state_q == RESP && oup_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    logic [$bits(inp_i.way_ind)-1:0] way_onehot;
    always_comb begin
        way_onehot             = '0;
        way_onehot[WayIndex]   = 1'b1;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (inp_i.way_ind == way_onehot));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (accept && !inp_i.we) |-> !mem_we);
endmodule

// File: tb/tb_axi_llc_data_way.sv
// tb/tb_axi_llc_data_way.sv - directed self-checking bench for axi_llc_data_way
module tb_axi_llc_data_way;
    typedef struct packed {
        logic [1:0]  cache_unit;
        logic [3:0]  way_ind;
        logic [1:0]  line_addr;
        logic [0:0]  blk_offset;
        logic        we;
        logic [63:0] data;
        logic [7:0]  strb;
    } inp_t;

    typedef struct packed {
        logic [1:0]  cache_unit;
        logic [63:0] read_data;
    } oup_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test = 1'b0;
    inp_t inp = '0;
    logic inp_valid = 1'b0;
    logic inp_ready;
    oup_t oup;
    logic oup_valid;
    logic oup_ready = 1'b1;
    logic init_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_llc_data_way #(
        .WayIndex (1),
        .NumLines (4),
        .NumBlocks(2),
        .DataWidth(64),
        .way_inp_t(inp_t),
        .way_oup_t(oup_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .test_i     (test),
        .inp_i      (inp),
        .inp_valid_i(inp_valid),
        .inp_ready_o(inp_ready),
        .oup_o      (oup),
        .oup_valid_o(oup_valid),
        .oup_ready_i(oup_ready),
        .init_done_o(init_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] line, input logic blk,
                         input logic [63:0] data, input logic [7:0] strb, input logic [1:0] unit);
        inp.cache_unit = unit;
        inp.way_ind    = 4'b0010;
        inp.line_addr  = line;
        inp.blk_offset = blk;
        inp.we         = we;
        inp.data       = data;
        inp.strb       = strb;
        inp_valid      = 1'b1;
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic write(input logic [1:0] line, input logic blk, input logic [63:0] data,
                         input logic [7:0] strb);
        drive(1'b1, line, blk, data, strb, 2'd0);
        @(negedge clk);
        inp_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] line, input logic blk,
                              input logic [1:0] unit, input logic [63:0] exp);
        drive(1'b0, line, blk, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA5, unit);
        @(negedge clk);
        inp_valid = 1'b0;
        check({tag, "_valid"}, 64'(oup_valid), 64'd1);
        check({tag, "_data"}, oup.read_data, exp);
        check({tag, "_unit"}, 64'(oup.cache_unit), 64'(unit));
        @(negedge clk);
    endtask

    task automatic wait_init(input string tag);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 64'({init_done, inp_ready}), 64'd0);
        end
        @(negedge clk);
        check({tag, "_done"}, 64'({init_done, inp_ready}), 64'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(oup_valid), 64'd0);
        check("rst_ready", 64'(inp_ready), 64'd0);
        check("rst_done", 64'(init_done), 64'd0);
        check("rst_oup", 64'(oup), 64'd0);
        rst_n = 1'b1;
        wait_init("init1");

        for (int a = 0; a < 8; a++) begin
            read_check("zero", 2'(a >> 1), 1'(a), 2'(a), 64'd0);
        end

        write(2'd3, 1'b1, 64'h1122_3344_5566_7788, 8'hFF);
        write(2'd3, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        read_check("merge", 2'd3, 1'b1, 2'd2, 64'h1122_3344_AAAA_AAAA);

        write(2'd0, 1'b0, 64'h100, 8'hFF);
        write(2'd0, 1'b1, 64'h201, 8'hFF);
        write(2'd1, 1'b0, 64'h302, 8'hFF);
        drive(1'b0, 2'd0, 1'b0, 64'd0, 8'h00, 2'd0);
        @(negedge clk);
        check("b2b0_ready", 64'(inp_ready), 64'd1);
        check("b2b0_data", oup.read_data, 64'h100);
        drive(1'b0, 2'd0, 1'b1, 64'd0, 8'h00, 2'd1);
        @(negedge clk);
        check("b2b1_ready", 64'(inp_ready), 64'd1);
        check("b2b1_valid", 64'(oup_valid), 64'd1);
        check("b2b1_data", oup.read_data, 64'h201);
        drive(1'b0, 2'd1, 1'b0, 64'd0, 8'h00, 2'd2);
        @(negedge clk);
        inp_valid = 1'b0;
        check("b2b2_valid", 64'(oup_valid), 64'd1);
        check("b2b2_data", oup.read_data, 64'h302);
        check("b2b2_unit", 64'(oup.cache_unit), 64'd2);
        @(negedge clk);
        check("b2b_end_valid", 64'(oup_valid), 64'd0);

        oup_ready = 1'b0;
        drive(1'b0, 2'd3, 1'b1, 64'd0, 8'h00, 2'd3);
        @(negedge clk);
        drive(1'b1, 2'd3, 1'b1, 64'd0, 8'hFF, 2'd0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(oup_valid), 64'd1);
            check("stall_data", oup.read_data, 64'h1122_3344_AAAA_AAAA);
            check("stall_unit", 64'(oup.cache_unit), 64'd3);
            check("stall_ready", 64'(inp_ready), 64'd0);
            @(negedge clk);
        end
        inp_valid = 1'b0;
        oup_ready = 1'b1;
        @(negedge clk);
        check("stall_release", 64'(oup_valid), 64'd0);
        read_check("stall_mem", 2'd3, 1'b1, 2'd1, 64'h1122_3344_AAAA_AAAA);

        drive(1'b0, 2'd2, 1'b0, 64'd0, 8'h00, 2'd1);
        @(negedge clk);
        check("hsw_valid", 64'(oup_valid), 64'd1);
        check("hsw_data", oup.read_data, 64'd0);
        drive(1'b1, 2'd2, 1'b0, 64'hDEAD_BEEF_0000_0000, 8'hFF, 2'd0);
        @(negedge clk);
        inp_valid = 1'b0;
        check("hsw_idle_valid", 64'(oup_valid), 64'd0);
        check("hsw_idle_ready", 64'(inp_ready), 64'd1);
        read_check("hsw_mem", 2'd2, 1'b0, 2'd0, 64'hDEAD_BEEF_0000_0000);

        drive(1'b0, 2'd2, 1'b0, 64'd0, 8'h00, 2'd2);
        @(negedge clk);
        inp_valid = 1'b0;
        check("rresp_valid", 64'(oup_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rresp_drop", 64'(oup_valid), 64'd0);
        check("rresp_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rinit_busy", 64'(init_done), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rinit_valid", 64'(oup_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init2");
        read_check("rst_mem20", 2'd2, 1'b0, 2'd1, 64'd0);
        read_check("rst_mem31", 2'd3, 1'b1, 2'd2, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
